exe_stage: RTL and testbench

- Execute stage of the ARM-subset 5-stage pipeline. It sits directly downstream of the ID/EXE pipeline register and consumes its outputs.
- Computes the second operand (Val2), the ALU result with NZCV flags, and the branch target.
- Owns the status register and the EXE/MEM pipeline register.
- Branch decision goes combinationally back to IF; all other results are registered toward MEM.

---
 rtl/arm_pkg.sv | 24 ++
 rtl/val2_generator.sv | 43 ++++
 rtl/exe_stage.sv | 149 ++++++++++++++
 tb/tb_exe_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ALU command, shift type and status flag encodings for the ARM-subset pipeline
package arm_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

endpackage

// File: rtl/val2_generator.sv
// rtl/val2_generator.sv - combinational second-operand generator (rotated immediate, memory offset, shifted register)
module val2_generator
  import arm_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] val_rm_i,
  input  logic              imm_i,
  input  logic              mem_en_i,
  input  logic [11:0]       shift_operand_i,
  output logic [WORD_W-1:0] val2_o
);

  logic [2*WORD_W-1:0] dbl;
  logic [4:0]          amt;

  always_comb begin
    dbl    = '0;
    amt    = '0;
    val2_o = '0;
    if (imm_i) begin
      amt    = {shift_operand_i[11:8], 1'b0};
      dbl    = {{(WORD_W-8){1'b0}}, shift_operand_i[7:0],
                {(WORD_W-8){1'b0}}, shift_operand_i[7:0]} >> amt;
      val2_o = dbl[WORD_W-1:0];
    end else if (mem_en_i) begin
      val2_o = {{(WORD_W-12){1'b0}}, shift_operand_i};
    end else begin
      amt = shift_operand_i[11:7];
      case (shift_operand_i[6:5])
        SH_LSL: val2_o = val_rm_i << amt;
        SH_LSR: val2_o = val_rm_i >> amt;
        SH_ASR: val2_o = $signed(val_rm_i) >>> amt;
        SH_ROR: begin
          dbl    = {val_rm_i, val_rm_i} >> amt;
          val2_o = dbl[WORD_W-1:0];
        end
        default: val2_o = val_rm_i;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: Val2, ALU with NZCV, branch target, status and EXE/MEM registers.
// Optional operand forwarding is built when FORWARDING_EN is defined.
module exe_stage
  import arm_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              WB_EN_IN,
  input  logic              MEM_R_EN_IN,
  input  logic              MEM_W_EN_IN,
  input  logic              B_IN,
  input  logic              S_IN,
  input  logic [3:0]        EXE_CMD_IN,
  input  logic [WORD_W-1:0] PC_IN,
  input  logic [WORD_W-1:0] Val_Rn_IN,
  input  logic [WORD_W-1:0] Val_Rm_IN,
  input  logic              imm_IN,
  input  logic [11:0]       Shift_operand_IN,
  input  logic [23:0]       Signed_imm_24_IN,
`ifdef FORWARDING_EN
  input  logic [1:0]        Sel_src1,
  input  logic [1:0]        Sel_src2,
  input  logic [WORD_W-1:0] MEM_ALU_Res,
  input  logic [WORD_W-1:0] WB_Value,
`endif
  input  logic [3:0]        Dest_IN,
  output logic              Br_taken,
  output logic [WORD_W-1:0] Br_addr,
  output logic [3:0]        SR,
  output logic              WB_EN,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic [WORD_W-1:0] ALU_Res,
  output logic [WORD_W-1:0] Val_Rm,
  output logic [3:0]        Dest
);

  localparam int MSB = WORD_W - 1;

  logic [WORD_W-1:0] rn_op, rm_op, val2;
  logic [WORD_W:0]   sum;
  logic [WORD_W-1:0] alu_res_d;
  logic              c_d, v_d;
  logic [3:0]        sr_d;

  logic [3:0]        sr_q;
  logic              wb_en_q, mem_r_en_q, mem_w_en_q;
  logic [WORD_W-1:0] alu_res_q, val_rm_q;
  logic [3:0]        dest_q;

`ifdef FORWARDING_EN
  always_comb begin
    case (Sel_src1)
      2'b01:   rn_op = MEM_ALU_Res;
      2'b10:   rn_op = WB_Value;
      default: rn_op = Val_Rn_IN;
    endcase
    case (Sel_src2)
      2'b01:   rm_op = MEM_ALU_Res;
      2'b10:   rm_op = WB_Value;
      default: rm_op = Val_Rm_IN;
    endcase
  end
`else
  assign rn_op = Val_Rn_IN;
  assign rm_op = Val_Rm_IN;
`endif

  val2_generator #(.WORD_W(WORD_W)) u_val2 (
    .val_rm_i        (rm_op),
    .imm_i           (imm_IN),
    .mem_en_i        (MEM_R_EN_IN | MEM_W_EN_IN),
    .shift_operand_i (Shift_operand_IN),
    .val2_o          (val2)
  );

  assign Br_taken = B_IN & ~flush;
  assign Br_addr  = PC_IN + {{(WORD_W-26){Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};

  // Borrow shows up as bit WORD_W of the 33-bit difference, so C is its inverse.
  always_comb begin
    sum       = '0;
    alu_res_d = '0;
    c_d       = sr_q[SR_C];
    v_d       = sr_q[SR_V];
    case (EXE_CMD_IN)
      CMD_MOV: alu_res_d = val2;
      CMD_MVN: alu_res_d = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum       = {1'b0, rn_op} + {1'b0, val2}
                  + {{WORD_W{1'b0}}, (EXE_CMD_IN == CMD_ADC) & sr_q[SR_C]};
        alu_res_d = sum[MSB:0];
        c_d       = sum[WORD_W];
        v_d       = (rn_op[MSB] == val2[MSB]) && (alu_res_d[MSB] != rn_op[MSB]);
      end
      CMD_SUB, CMD_SBC: begin
        sum       = {1'b0, rn_op} - {1'b0, val2}
                  - {{WORD_W{1'b0}}, (EXE_CMD_IN == CMD_SBC) & ~sr_q[SR_C]};
        alu_res_d = sum[MSB:0];
        c_d       = ~sum[WORD_W];
        v_d       = (rn_op[MSB] != val2[MSB]) && (alu_res_d[MSB] != rn_op[MSB]);
      end
      CMD_AND: alu_res_d = rn_op & val2;
      CMD_ORR: alu_res_d = rn_op | val2;
      CMD_EOR: alu_res_d = rn_op ^ val2;
      default: alu_res_d = '0;
    endcase
    sr_d = {alu_res_d[MSB], (alu_res_d == '0), c_d, v_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (S_IN && !flush && !freeze) begin
      sr_q <= sr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= '0;
      val_rm_q   <= '0;
      dest_q     <= '0;
    end else if (!freeze) begin
      wb_en_q    <= WB_EN_IN & ~flush;
      mem_r_en_q <= MEM_R_EN_IN & ~flush;
      mem_w_en_q <= MEM_W_EN_IN & ~flush;
      alu_res_q  <= alu_res_d;
      val_rm_q   <= rm_op;
      dest_q     <= Dest_IN;
    end
  end

  assign SR       = sr_q;
  assign WB_EN    = wb_en_q;
  assign MEM_R_EN = mem_r_en_q;
  assign MEM_W_EN = mem_w_en_q;
  assign ALU_Res  = alu_res_q;
  assign Val_Rm   = val_rm_q;
  assign Dest     = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed self-checking bench for exe_stage
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, flush;
  logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN;
  logic [3:0]  EXE_CMD_IN;
  logic [31:0] PC_IN, Val_Rn_IN, Val_Rm_IN;
  logic        imm_IN;
  logic [11:0] Shift_operand_IN;
  logic [23:0] Signed_imm_24_IN;
  logic [3:0]  Dest_IN;
  logic        Br_taken;
  logic [31:0] Br_addr;
  logic [3:0]  SR;
  logic        WB_EN, MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_Res, Val_Rm;
  logic [3:0]  Dest;

  int checks   = 0;
  int failures = 0;

  exe_stage dut (
    .clk              (clk),
    .rst              (rst),
    .freeze           (freeze),
    .flush            (flush),
    .WB_EN_IN         (WB_EN_IN),
    .MEM_R_EN_IN      (MEM_R_EN_IN),
    .MEM_W_EN_IN      (MEM_W_EN_IN),
    .B_IN             (B_IN),
    .S_IN             (S_IN),
    .EXE_CMD_IN       (EXE_CMD_IN),
    .PC_IN            (PC_IN),
    .Val_Rn_IN        (Val_Rn_IN),
    .Val_Rm_IN        (Val_Rm_IN),
    .imm_IN           (imm_IN),
    .Shift_operand_IN (Shift_operand_IN),
    .Signed_imm_24_IN (Signed_imm_24_IN),
    .Dest_IN          (Dest_IN),
    .Br_taken         (Br_taken),
    .Br_addr          (Br_addr),
    .SR               (SR),
    .WB_EN            (WB_EN),
    .MEM_R_EN         (MEM_R_EN),
    .MEM_W_EN         (MEM_W_EN),
    .ALU_Res          (ALU_Res),
    .Val_Rm           (Val_Rm),
    .Dest             (Dest)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                       input logic im, input logic [11:0] shop, input logic s,
                       input logic wb, input logic mw, input logic [3:0] dst);
    EXE_CMD_IN       = cmd;
    Val_Rn_IN        = rn;
    Val_Rm_IN        = rm;
    imm_IN           = im;
    Shift_operand_IN = shop;
    S_IN             = s;
    WB_EN_IN         = wb;
    MEM_R_EN_IN      = 1'b0;
    MEM_W_EN_IN      = mw;
    Dest_IN          = dst;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; B_IN = 1'b0;
    PC_IN = '0; Signed_imm_24_IN = '0;
    issue(4'h0, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    check_eq("reset_sr", {28'h0, SR}, 32'h0);
    check_eq("reset_alu", ALU_Res, 32'h0);
    check_eq("reset_wb", {31'h0, WB_EN}, 32'h0);
    rst = 1'b0;

    issue(4'b0010, 32'h7FFFFFFF, 32'h0, 1'b1, 12'h001, 1'b1, 1'b1, 1'b0, 4'h3);
    tick();
    check_eq("add_res", ALU_Res, 32'h80000000);
    check_eq("add_sr", {28'h0, SR}, 32'h9);
    check_eq("add_wb", {31'h0, WB_EN}, 32'h1);
    check_eq("add_dest", {28'h0, Dest}, 32'h3);

    issue(4'b0000, 32'h12345678, 32'h0, 1'b1, 12'h0FF, 1'b1, 1'b1, 1'b0, 4'h1);
    tick();
    check_eq("undef_res", ALU_Res, 32'h0);
    check_eq("undef_sr", {28'h0, SR}, 32'h5);

    issue(4'b0100, 32'h5, 32'h0, 1'b1, 12'h005, 1'b1, 1'b1, 1'b0, 4'h1);
    tick();
    check_eq("sub_res", ALU_Res, 32'h0);
    check_eq("sub_sr", {28'h0, SR}, 32'h6);

    issue(4'b0011, 32'h1, 32'h0, 1'b1, 12'h001, 1'b1, 1'b1, 1'b0, 4'h1);
    tick();
    check_eq("adc_res", ALU_Res, 32'h3);
    check_eq("adc_sr", {28'h0, SR}, 32'h0);

    issue(4'b0001, 32'h0, 32'h0, 1'b1, 12'h4FF, 1'b0, 1'b1, 1'b0, 4'h2);
    tick();
    check_eq("imm_rot", ALU_Res, 32'hFF000000);

    issue(4'b0001, 32'h0, 32'h80000000, 1'b0, 12'h240, 1'b0, 1'b1, 1'b0, 4'h2);
    tick();
    check_eq("asr4", ALU_Res, 32'hF8000000);

    issue(4'b0001, 32'h0, 32'h000000F1, 1'b0, 12'h260, 1'b0, 1'b1, 1'b0, 4'h2);
    tick();
    check_eq("ror4", ALU_Res, 32'h1000000F);

    issue(4'b0001, 32'h0, 32'h12345678, 1'b0, 12'h060, 1'b0, 1'b1, 1'b0, 4'h2);
    tick();
    check_eq("ror0_pass", ALU_Res, 32'h12345678);

    issue(4'b0001, 32'h0, 32'h80000000, 1'b0, 12'hFA0, 1'b0, 1'b1, 1'b0, 4'h2);
    tick();
    check_eq("lsr31", ALU_Res, 32'h1);

    issue(4'b0010, 32'h1000, 32'hDEADBEEF, 1'b0, 12'hABC, 1'b0, 1'b0, 1'b1, 4'h5);
    tick();
    check_eq("mem_off", ALU_Res, 32'h1ABC);
    check_eq("mem_w", {31'h0, MEM_W_EN}, 32'h1);
    check_eq("mem_rm", Val_Rm, 32'hDEADBEEF);

    issue(4'b0100, 32'h0, 32'h0, 1'b1, 12'h001, 1'b1, 1'b1, 1'b0, 4'h1);
    tick();
    check_eq("sub_borrow_res", ALU_Res, 32'hFFFFFFFF);
    check_eq("sub_borrow_sr", {28'h0, SR}, 32'h8);

    issue(4'b0101, 32'd10, 32'h0, 1'b1, 12'h003, 1'b1, 1'b1, 1'b0, 4'h1);
    tick();
    check_eq("sbc_res", ALU_Res, 32'd6);
    check_eq("sbc_sr", {28'h0, SR}, 32'h2);

    issue(4'b0110, 32'hF0, 32'h0, 1'b1, 12'h00F, 1'b1, 1'b1, 1'b0, 4'h1);
    tick();
    check_eq("and_res", ALU_Res, 32'h0);
    check_eq("and_sr", {28'h0, SR}, 32'h6);

    issue(4'b0111, 32'hF0, 32'h0, 1'b1, 12'h00F, 1'b0, 1'b1, 1'b0, 4'h1);
    tick();
    check_eq("orr_res", ALU_Res, 32'hFF);

    issue(4'b1000, 32'hFF, 32'h0, 1'b1, 12'h00F, 1'b0, 1'b1, 1'b0, 4'h1);
    tick();
    check_eq("eor_res", ALU_Res, 32'hF0);

    issue(4'b1001, 32'h0, 32'h0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0, 4'h1);
    tick();
    check_eq("mvn_res", ALU_Res, 32'hFFFFFFFF);

    PC_IN = 32'h100; Signed_imm_24_IN = 24'hFFFFFE; B_IN = 1'b1;
    #1;
    check_eq("br_addr_back", Br_addr, 32'hF8);
    check_eq("br_taken", {31'h0, Br_taken}, 32'h1);
    Signed_imm_24_IN = 24'h000004;
    #1;
    check_eq("br_addr_fwd", Br_addr, 32'h110);

    flush = 1'b1;
    issue(4'b0010, 32'h7FFFFFFF, 32'h0, 1'b1, 12'h001, 1'b1, 1'b1, 1'b1, 4'h1);
    #1;
    check_eq("br_flushed", {31'h0, Br_taken}, 32'h0);
    tick();
    check_eq("flush_wb", {31'h0, WB_EN}, 32'h0);
    check_eq("flush_memw", {31'h0, MEM_W_EN}, 32'h0);
    check_eq("flush_sr", {28'h0, SR}, 32'h6);
    flush = 1'b0; B_IN = 1'b0;

    issue(4'b0001, 32'h0, 32'h0, 1'b1, 12'h055, 1'b0, 1'b1, 1'b0, 4'h7);
    tick();
    check_eq("pre_freeze", ALU_Res, 32'h55);

    freeze = 1'b1;
    issue(4'b0010, 32'h7FFFFFFF, 32'h0, 1'b1, 12'h001, 1'b1, 1'b0, 1'b0, 4'h9);
    tick();
    tick();
    check_eq("freeze_res", ALU_Res, 32'h55);
    check_eq("freeze_sr", {28'h0, SR}, 32'h6);
    check_eq("freeze_dest", {28'h0, Dest}, 32'h7);
    flush = 1'b1; B_IN = 1'b1;
    #1;
    check_eq("freeze_flush_br", {31'h0, Br_taken}, 32'h0);
    tick();
    check_eq("freeze_flush_wb", {31'h0, WB_EN}, 32'h1);
    flush = 1'b0; B_IN = 1'b0;
    freeze = 1'b0;
    tick();
    check_eq("release_res", ALU_Res, 32'h80000000);
    check_eq("release_sr", {28'h0, SR}, 32'h9);
    check_eq("release_wb", {31'h0, WB_EN}, 32'h0);

    freeze = 1'b1; rst = 1'b1;
    tick();
    check_eq("rst_prio_sr", {28'h0, SR}, 32'h0);
    check_eq("rst_prio_res", ALU_Res, 32'h0);
    rst = 1'b0; freeze = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
